// File: rtl/set_injector_pkg.sv
// Shared types and defaults for the set_injector register bank.
// Optional checker is enabled by defining SET_INJECTOR_CHECK_EN.
package set_injector_pkg;

  typedef enum logic [1:0] {
    WR_LEVEL   = 2'd0,
    WR_PULSE   = 2'd1,
    WR_RESTORE = 2'd2,
    WR_RSVD    = 2'd3
  } wr_mode_t;

  localparam int DEFAULT_SET_SIZE    = 5;
  localparam int DEFAULT_SET_WIDTH   = 32;
  localparam int DEFAULT_CHECK_SIZE  = 5;
  localparam int DEFAULT_CHECK_WIDTH = 32;

  // Select-field width for n entries; a single entry still gets one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/set_injector_chan.sv
// One injector channel: output register, saved pre-pulse value,
// pulse-pending flag and restore-to-init logic.
module set_injector_chan
  import set_injector_pkg::*;
#(
  parameter int WIDTH = DEFAULT_SET_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,      // synchronous, active-high
  input  logic             wr_en,      // write addressed to this channel
  input  wr_mode_t         wr_mode,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] init_value,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] saved_q;
  logic             pend_q;
  logic             take;

  // Reserved mode never touches a channel, so it behaves like no write.
  assign take  = wr_en && (wr_mode != WR_RSVD);
  assign value = value_q;

  // Output register and pending-revert flag; a new write overrides any revert.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      value_q <= init_value;
      pend_q  <= 1'b0;
    end else if (take) begin
      case (wr_mode)
        WR_LEVEL: begin
          value_q <= wr_data;
          pend_q  <= 1'b0;
        end
        WR_PULSE: begin
          value_q <= wr_data;
          pend_q  <= 1'b1;
        end
        default: begin
          value_q <= init_value;
          pend_q  <= 1'b0;
        end
      endcase
    end else if (pend_q) begin
      value_q <= saved_q;
      pend_q  <= 1'b0;
    end
  end

  // Capture the value visible before a pulse so it can be restored next edge.
  // NOTE: saved_q has no reset; it is only read while pend_q is set, and
  // pend_q is always cleared by reset.
  always_ff @(posedge clk) begin
    if (take && (wr_mode == WR_PULSE)) begin
      saved_q <= value_q;
    end
  end

endmodule

// File: rtl/set_injector.sv
// Multi-channel stimulus register bank with an optional level checker.
// Define SET_INJECTOR_CHECK_EN to include the checker ports and logic.
module set_injector
  import set_injector_pkg::*;
#(
  parameter int SET_SIZE    = DEFAULT_SET_SIZE,
  parameter int SET_WIDTH   = DEFAULT_SET_WIDTH,
  parameter int CHECK_SIZE  = DEFAULT_CHECK_SIZE,
  parameter int CHECK_WIDTH = DEFAULT_CHECK_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,  // synchronous, active-high
  input  logic [SET_SIZE*SET_WIDTH-1:0]     i_init_value,
  input  logic                              i_wr_en,
  input  logic [sel_width(SET_SIZE)-1:0]    i_wr_sel,
  input  logic [SET_WIDTH-1:0]              i_wr_data,
  input  logic [1:0]                        i_wr_mode,
  output logic [SET_SIZE*SET_WIDTH-1:0]     o_set_signals,
  output logic                              o_wr_err
`ifdef SET_INJECTOR_CHECK_EN
  ,
  input  logic [CHECK_SIZE*CHECK_WIDTH-1:0] i_check_signals,
  input  logic                              i_chk_en,
  input  logic [sel_width(CHECK_SIZE)-1:0]  i_chk_sel,
  input  logic [CHECK_WIDTH-1:0]            i_chk_value,
  output logic                              o_chk_done,
  output logic                              o_chk_ok
`endif
);

  if (SET_SIZE < 1 || SET_WIDTH < 1 || CHECK_SIZE < 1 || CHECK_WIDTH < 1) begin : g_bad_cfg
    $error("set_injector: all size and width parameters must be at least 1");
  end

  wr_mode_t wr_mode;
  logic     wr_reject;
  logic     wr_err_q;

  assign wr_mode   = wr_mode_t'(i_wr_mode);
  assign wr_reject = i_wr_en && ((int'(i_wr_sel) >= SET_SIZE) || (wr_mode == WR_RSVD));
  assign o_wr_err  = wr_err_q;

  // One-cycle error flag for a write that addresses no channel or uses a reserved mode.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_reject;
    end
  end

  for (genvar k = 0; k < SET_SIZE; k++) begin : g_chan
    set_injector_chan #(
      .WIDTH (SET_WIDTH)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (i_wr_en && (int'(i_wr_sel) == k)),
      .wr_mode    (wr_mode),
      .wr_data    (i_wr_data),
      .init_value (i_init_value[k*SET_WIDTH +: SET_WIDTH]),
      .value      (o_set_signals[k*SET_WIDTH +: SET_WIDTH])
    );
  end

`ifdef SET_INJECTOR_CHECK_EN
  logic chk_hit;
  logic chk_done_q;
  logic chk_ok_q;

  // Exact match of the selected monitored word; out-of-range selects never match.
  // NOTE: chk_hit gets its default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < CHECK_SIZE; i++) begin
      if ((int'(i_chk_sel) == i) &&
          (i_check_signals[i*CHECK_WIDTH +: CHECK_WIDTH] == i_chk_value)) begin
        chk_hit = 1'b1;
      end
    end
  end

  // Register the check result; ok is qualified by the request so it is 0 when done is 0.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      chk_done_q <= 1'b0;
      chk_ok_q   <= 1'b0;
    end else begin
      chk_done_q <= i_chk_en;
      chk_ok_q   <= i_chk_en && chk_hit;
    end
  end

  assign o_chk_done = chk_done_q;
  assign o_chk_ok   = chk_ok_q;
`endif

endmodule

// File: tb/tb_set_injector.sv
// Scoreboard bench for set_injector: the driver pushes hand-computed
// expectations per vector, a monitor pops and compares after each edge.
// Checker vectors are compared only when SET_INJECTOR_CHECK_EN is defined.
module tb_set_injector;

  localparam int N   = 5;
  localparam int W   = 32;
  localparam int TOT = N * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n = 1'b0;
  logic [TOT-1:0] init_value = '0;
  logic           wr_en = 1'b0;
  logic [2:0]     wr_sel = '0;
  logic [W-1:0]   wr_data = '0;
  logic [1:0]     wr_mode = '0;
  logic [TOT-1:0] set_signals;
  logic           wr_err;
  logic [TOT-1:0] check_signals = '0;
  logic           chk_en = 1'b0;
  logic [2:0]     chk_sel = '0;
  logic [W-1:0]   chk_value = '0;
  logic           chk_done;
  logic           chk_ok;

  set_injector #(
    .SET_SIZE    (N),
    .SET_WIDTH   (W),
    .CHECK_SIZE  (N),
    .CHECK_WIDTH (W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_init_value    (init_value),
    .i_wr_en         (wr_en),
    .i_wr_sel        (wr_sel),
    .i_wr_data       (wr_data),
    .i_wr_mode       (wr_mode),
    .o_set_signals   (set_signals),
    .o_wr_err        (wr_err)
`ifdef SET_INJECTOR_CHECK_EN
    ,
    .i_check_signals (check_signals),
    .i_chk_en        (chk_en),
    .i_chk_sel       (chk_sel),
    .i_chk_value     (chk_value),
    .o_chk_done      (chk_done),
    .o_chk_ok        (chk_ok)
`endif
  );

`ifndef SET_INJECTOR_CHECK_EN
  assign chk_done = 1'b0;
  assign chk_ok   = 1'b0;
`endif

  typedef struct {
    logic [TOT-1:0] set;
    logic           err;
    logic           done;
    logic           ok;
    int             id;
  } exp_t;

  exp_t         sb_q[$];
  int           n_vec  = 0;
  int           n_bad  = 0;
  int           vec_id = 0;
  logic [W-1:0] exp_ch [N];

  task automatic check(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h", name, act, req);
    end
  endtask

  function automatic logic [TOT-1:0] pack_exp();
    logic [TOT-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = exp_ch[k];
    return v;
  endfunction

  // Drive one vector at the falling edge and record what must appear after the next rising edge.
  task automatic apply(input logic rst, input logic en, input logic [2:0] sel,
                       input logic [W-1:0] data, input logic [1:0] mode, input logic exp_err,
                       input logic c_en = 1'b0, input logic [2:0] c_sel = 3'd0,
                       input logic [W-1:0] c_val = '0,
                       input logic exp_done = 1'b0, input logic exp_ok = 1'b0);
    exp_t e;
    @(negedge clk);
    rst_n     = rst;
    wr_en     = en;
    wr_sel    = sel;
    wr_data   = data;
    wr_mode   = mode;
    chk_en    = c_en;
    chk_sel   = c_sel;
    chk_value = c_val;
    e.set  = pack_exp();
    e.err  = exp_err;
    e.done = exp_done;
    e.ok   = exp_ok;
    e.id   = vec_id;
    vec_id++;
    sb_q.push_back(e);
  endtask

  task automatic load_init_exp();
    exp_ch[0] = 32'hAAAAAAAA;
    exp_ch[1] = 32'h22222222;
    exp_ch[2] = 32'h55555555;
    exp_ch[3] = 32'h00000000;
    exp_ch[4] = 32'hFFFFFFFF;
  endtask

  // Monitor: compare outputs shortly after every rising edge that has a pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("v%0d set_signals", e.id), set_signals, e.set);
        check($sformatf("v%0d wr_err", e.id), TOT'(wr_err), TOT'(e.err));
`ifdef SET_INJECTOR_CHECK_EN
        check($sformatf("v%0d chk_done", e.id), TOT'(chk_done), TOT'(e.done));
        check($sformatf("v%0d chk_ok", e.id), TOT'(chk_ok), TOT'(e.ok));
`endif
      end
    end
  end

  initial begin
    init_value    = {32'hFFFFFFFF, 32'h00000000, 32'h55555555, 32'h22222222, 32'hAAAAAAAA};
    check_signals = {32'hCAFEDEC3, 32'hCAFEDEC2, 32'hCAFEDEC1, 32'hCAFEDEC0, 32'hCAFEDECA};
    load_init_exp();

    // Reset with a write and a check presented: both ignored.
    apply(1'b1, 1'b1, 3'd1, 32'hDEADBEEF, 2'd0, 1'b0, 1'b1, 3'd1, 32'hCAFEDEC0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
    // Idle after reset; matching check on word 1.
    apply(1'b0, 1'b0, 3'd0, 32'h0, 2'd0, 1'b0, 1'b1, 3'd1, 32'hCAFEDEC0, 1'b1, 1'b1);
    // Level write to channel 2; non-matching check.
    exp_ch[2] = 32'h12345678;
    apply(1'b0, 1'b1, 3'd2, 32'h12345678, 2'd0, 1'b0, 1'b1, 3'd1, 32'hCAFEDEC1, 1'b1, 1'b0);
    // Idle; out-of-range check select never matches.
    apply(1'b0, 1'b0, 3'd0, 32'h0, 2'd0, 1'b0, 1'b1, 3'd5, 32'hCAFEDECA, 1'b1, 1'b0);
    // Pulse 0 on channel 4, then revert to FFFFFFFF; matching check on word 0.
    exp_ch[4] = 32'h00000000;
    apply(1'b0, 1'b1, 3'd4, 32'h00000000, 2'd1, 1'b0);
    exp_ch[4] = 32'hFFFFFFFF;
    apply(1'b0, 1'b0, 3'd0, 32'h0, 2'd0, 1'b0, 1'b1, 3'd0, 32'hCAFEDECA, 1'b1, 1'b1);
    // Pulse, then a level write in the pulse cycle cancels the revert.
    exp_ch[4] = 32'h00000000;
    apply(1'b0, 1'b1, 3'd4, 32'h00000000, 2'd1, 1'b0);
    exp_ch[4] = 32'h00000001;
    apply(1'b0, 1'b1, 3'd4, 32'h00000001, 2'd0, 1'b0);
    apply(1'b0, 1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
    // Level write then restore on channel 0 (data ignored).
    exp_ch[0] = 32'h13579BDF;
    apply(1'b0, 1'b1, 3'd0, 32'h13579BDF, 2'd0, 1'b0);
    exp_ch[0] = 32'hAAAAAAAA;
    apply(1'b0, 1'b1, 3'd0, 32'hFFFF0000, 2'd2, 1'b0);
    // Rejected writes: select out of range, then reserved mode.
    apply(1'b0, 1'b1, 3'd5, 32'h00000005, 2'd0, 1'b1);
    apply(1'b0, 1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
    apply(1'b0, 1'b1, 3'd1, 32'h77777777, 2'd3, 1'b1);
    // Pulse channel 3; a write to channel 1 in the pulse cycle leaves the revert intact.
    exp_ch[3] = 32'h0F0F0F0F;
    apply(1'b0, 1'b1, 3'd3, 32'h0F0F0F0F, 2'd1, 1'b0);
    exp_ch[3] = 32'h00000000;
    exp_ch[1] = 32'h11111111;
    apply(1'b0, 1'b1, 3'd1, 32'h11111111, 2'd0, 1'b0);
    // Reset mid-pulse: init values win and no revert follows.
    exp_ch[2] = 32'hBEEF0000;
    apply(1'b0, 1'b1, 3'd2, 32'hBEEF0000, 2'd1, 1'b0);
    load_init_exp();
    apply(1'b1, 1'b0, 3'd0, 32'h0, 2'd0, 1'b0);
    apply(1'b0, 1'b0, 3'd0, 32'h0, 2'd0, 1'b0);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, wanted 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/set_injector.md
# set_injector

Synchronous multi-channel stimulus register bank with an optional level checker. It holds `SET_SIZE` independent output words of `SET_WIDTH` bits, each loaded with a per-channel initial value at reset and updated by a single write port. It sits between a test sequencer, or any register-write master, and the signals it drives. The optional checker compares one selected monitored word against an expected value and reports pass/fail.

## Interface
- `SET_SIZE`, 5: number of injector channels (≥1).
- `SET_WIDTH`, 32: bits per injector channel.
- `CHECK_SIZE`, 5: number of monitored words (≥1).
- `CHECK_WIDTH`, 32: bits per monitored word.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  synchronous reset, **active-high** despite the name.
- `i_init_value`  in  SET_SIZE*SET_WIDTH  per-channel reset values; channel k occupies bits [k*SET_WIDTH +: SET_WIDTH].
- `i_wr_en`  in  1  write strobe, sampled each cycle.
- `i_wr_sel`  in  max(1,$clog2(SET_SIZE))  target channel.
- `i_wr_data`  in  SET_WIDTH  write value.
- `i_wr_mode`  in  2  0 = level, 1 = pulse, 2 = restore init, 3 = reserved.
- `o_set_signals`  out  SET_SIZE*SET_WIDTH  channel outputs, same packing as `i_init_value`.
- `o_wr_err`  out  1  one-cycle flag for a rejected write.
- `i_check_signals`  in  CHECK_SIZE*CHECK_WIDTH  monitored words (checker only).
- `i_chk_en`, `i_chk_sel`, `i_chk_value`  in  1 / max(1,$clog2(CHECK_SIZE)) / CHECK_WIDTH  check request (checker only).
- `o_chk_done`, `o_chk_ok`  out  1 / 1  check result (checker only).

## Operation
- **Reset** (`rst_n`=1 at a rising edge):
  - every channel register loads its slice of `i_init_value`;
  - all pending-pulse state clears;
  - `o_wr_err`, `o_chk_done` and `o_chk_ok` = 0.
  - Writes and checks presented during reset are ignored.
- **Level write** (mode 0): channel `i_wr_sel` takes `i_wr_data` and holds it indefinitely.
- **Pulse write** (mode 1):
  - channel takes `i_wr_data` for exactly one cycle;
  - the channel's pre-write value is saved;
  - on the next edge the channel reverts to the saved value.
- **Restore write** (mode 2): channel reloads its current `i_init_value` slice; `i_wr_data` is ignored.
- **Rejected writes**: if `i_wr_sel` ≥ `SET_SIZE` or mode = 3, no channel changes and `o_wr_err`=1 for one cycle.
- **Write during an active pulse**:
  - A write to the pulsed channel in its pulse cycle wins and cancels the pending revert.
  - A write to a different channel does not disturb the pending revert.
- **Channel independence**: only one channel changes per write. Other channels, and the pending revert from the previous cycle, are unaffected.
- **Checker**:
  - Samples `i_check_signals[i_chk_sel]` and `i_chk_value` when `i_chk_en`=1.
  - `o_chk_ok` = 1 on exact equality, including all bits.
  - `i_chk_sel` ≥ `CHECK_SIZE` gives `o_chk_ok`=0.

## Timing
- Write visible on `o_set_signals` the cycle after the edge that samples `i_wr_en`; latency is 1, and one write per cycle is accepted back-to-back.
- A pulse value is visible for exactly one clock period, then the saved value returns.
- `o_wr_err`: registered, asserted in the cycle after the rejected write.
- `o_chk_done`:
  - registered; high for one cycle, the cycle after `i_chk_en`;
  - `o_chk_ok` is valid only while `o_chk_done`=1 and is 0 otherwise.
- Reset asserted mid-pulse: reset values take priority and no revert occurs afterwards.

## Configuration
- Macro `SET_INJECTOR_CHECK_EN` defined: the checker ports and logic are present.
- Macro absent:
  - the `i_check_signals`, `i_chk_*` and `o_chk_*` ports are omitted;
  - `CHECK_SIZE` and `CHECK_WIDTH` remain declared but are unused.

## Structure
- Shared package `set_injector_pkg` holds:
  - mode enum `wr_mode_t` (`WR_LEVEL`, `WR_PULSE`, `WR_RESTORE`, `WR_RSVD`);
  - default size and width constants.
- One natural sub-module, `set_injector_chan`: one register, saved value, pulse-pending flag, and restore logic, instantiated `SET_SIZE` times via generate.
- The checker is inline logic guarded by the macro.

## Test plan
- **Reset load**: init = {AAAAAAAA, 22222222, 55555555, 00000000, FFFFFFFF}, release reset -> outputs equal those values; `o_wr_err`=0.
- **Level write**: level write of 12345678 to channel 2 -> channel 2 = 12345678 from the next cycle; other channels unchanged.
- **Pulse write**: pulse write of 0 to channel 4 -> channel 4 = 00000000 for one cycle, then FFFFFFFF. A level write of 1 to channel 4 in that pulse cycle -> channel 4 stays 00000001.
- **Restore**: after a level write to channel 0, a restore write -> channel 0 = AAAAAAAA.
- **Rejected writes**: `i_wr_sel`=5 or mode 3 -> no output change; `o_wr_err` high for one cycle.
- **Checker** (`SET_INJECTOR_CHECK_EN`): check words {CAFEDECA, CAFEDEC0, CAFEDEC1, CAFEDEC2, CAFEDEC3}.
  - sel 1, expected CAFEDEC0 -> `o_chk_done`=1 and `o_chk_ok`=1 next cycle;
  - expected CAFEDEC1 -> `o_chk_ok`=0.
